// File: rtl/keycode_event_queue.sv
// Turns the keycode PIO level into press/release (and optional auto-repeat) events queued in a FIFO.
// Auto-repeat is built only when KEYCODE_EVT_REPEAT_EN is defined.
module keycode_event_queue #(
  parameter int DEPTH         = 8,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [7:0]             keycode,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [9:0]             evt_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   clear_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  // Elaborates to nothing; it only documents the legal parameter range.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_params
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_HELD,
    S_SWAP
`ifdef KEYCODE_EVT_REPEAT_EN
    , S_RPT
`endif
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  k_r;
  logic [7:0]  held, held_nx;
  logic        push;
  logic [9:0]  push_data;

`ifdef KEYCODE_EVT_REPEAT_EN
  localparam logic [24:0] DELAY_LAST  = 25'(REPEAT_DELAY - 1);
  localparam logic [24:0] PERIOD_LAST = 25'(REPEAT_PERIOD - 1);
  logic [24:0] cnt, cnt_nx;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      k_r   <= '0;
      held  <= '0;
`ifdef KEYCODE_EVT_REPEAT_EN
      cnt   <= '0;
`endif
    end else begin
      state <= state_nx;
      k_r   <= keycode;
      held  <= held_nx;
`ifdef KEYCODE_EVT_REPEAT_EN
      cnt   <= cnt_nx;
`endif
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves a latch behind.
  always_comb begin
    state_nx  = state;
    held_nx   = held;
    push      = 1'b0;
    push_data = '0;
`ifdef KEYCODE_EVT_REPEAT_EN
    cnt_nx    = cnt;
`endif
    case (state)
      S_IDLE, S_SWAP: begin
        if (k_r != 8'd0) begin
          push      = 1'b1;
          push_data = {2'b01, k_r};
          held_nx   = k_r;
          state_nx  = S_HELD;
`ifdef KEYCODE_EVT_REPEAT_EN
          cnt_nx    = '0;
`endif
        end else begin
          state_nx  = S_IDLE;
        end
      end
`ifdef KEYCODE_EVT_REPEAT_EN
      S_HELD, S_RPT: begin
`else
      S_HELD: begin
`endif
        // A key change beats a repeat expiry landing in the same cycle.
        if (k_r != held) begin
          push      = 1'b1;
          push_data = {2'b00, held};
          state_nx  = (k_r == 8'd0) ? S_IDLE : S_SWAP;
        end
`ifdef KEYCODE_EVT_REPEAT_EN
        else begin
          cnt_nx = cnt + 25'd1;
          if (cnt == ((state == S_HELD) ? DELAY_LAST : PERIOD_LAST)) begin
            push      = 1'b1;
            push_data = {2'b11, held};
            cnt_nx    = '0;
            state_nx  = S_RPT;
          end
        end
`endif
      end
      default: state_nx = S_IDLE;
    endcase
  end

  logic [9:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, pop, push_ok;

  assign full      = (level == LW'(DEPTH));
  assign pop       = evt_valid && evt_ready;
  // When full, a same-cycle pop frees the slot the write lands in.
  assign push_ok   = push && (!full || pop);
  assign evt_valid = (level != '0);
  assign evt_data  = mem[rd_ptr];

  // NOTE: storage is not reset; level gates visibility, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
      else if (clear_overflow)  overflow <= 1'b0;
    end
  end

endmodule
